// File: rtl/ram_port_arbiter_pkg.sv
// Shared sizing, FSM encoding and port indices for the two-port RAM arbiter.
package ram_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker, purely combinational.
// On a tie the port that was not served last wins.
module rr_pick2
    import ram_port_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        if (req_i == 2'b11) begin
            grant_o = ~last_i;
        end else if (req_i[1]) begin
            grant_o = PORT1;
        end else begin
            grant_o = PORT0;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between two req/ack masters: IDLE -> ACCESS -> DONE,
// three cycles per access, registered one-cycle ack with the read data.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_datain,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dataout
);

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              pick;
    logic              pick_vld;

    rr_pick2 u_pick (
        .req_i   ({m1_req, m0_req}),
        .last_i  (last_q),
        .grant_o (pick),
        .valid_o (pick_vld)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    win_d   = pick;
                    last_d  = pick;
                    addr_d  = (pick == PORT1) ? m1_addr  : m0_addr;
                    we_d    = (pick == PORT1) ? m1_we    : m0_we;
                    wdata_d = (pick == PORT1) ? m1_wdata : m0_wdata;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Read is combinational, so on a write this captures the pre-write byte.
                if (win_q == PORT1) begin
                    rdata1_d = ram_dataout;
                    ack1_d   = 1'b1;
                end else begin
                    rdata0_d = ram_dataout;
                    ack0_d   = 1'b1;
                end
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= PORT1;
            win_q    <= PORT0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Gating on state means an async reset mid-ACCESS drops the strobe before the edge.
    assign ram_we      = we_q && (state_q == ST_ACCESS);
    assign ram_address = addr_q;
    assign ram_datain  = wdata_q;
    assign m0_ack      = ack0_q;
    assign m1_ack      = ack1_q;
    assign m0_rdata    = rdata0_q;
    assign m1_rdata    = rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter with a combinational-read RAM and a transaction-level reference model.
module tb_ram_port_arbiter;

    localparam int AW = 15;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_ack, m1_ack, ram_we;
    logic [DW-1:0] m0_rdata, m1_rdata, ram_datain, ram_dataout;
    logic [AW-1:0] ram_address;

    logic [DW-1:0] mem     [0:32767];
    logic [DW-1:0] ref_mem [0:32767];

    int errors = 0;
    int checks = 0;
    int we_cnt = 0, ack_cnt0 = 0, ack_cnt1 = 0;
    logic [AW-1:0] we_addr_seen = '0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_address(ram_address), .ram_datain(ram_datain), .ram_we(ram_we),
        .ram_dataout(ram_dataout)
    );

    assign ram_dataout = mem[ram_address];
    always @(posedge clk) if (ram_we) mem[ram_address] <= ram_datain;

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 0)  return 8'h04;
        if (i == 17) return 8'h08;
        if (i == 18) return 8'h01;
        return 8'(i * 7 + 3);
    endfunction

    function automatic logic pick_ref(input logic r0, input logic r1, input logic last);
        if (r0 && r1) return !last;
        return r1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a transaction occupies three cycles (grant, RAM access, ack).
    int            tphase;
    logic          mwin, mlast, mwe;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwd, mrd0, mrd1;
    logic [1:0]    mack;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tphase <= 0; mlast <= 1'b1; mwin <= 1'b0; mwe <= 1'b0;
            maddr <= '0; mwd <= '0; mrd0 <= '0; mrd1 <= '0; mack <= 2'b00;
        end else begin
            mack <= 2'b00;
            if (tphase == 0) begin
                if (m0_req || m1_req) begin
                    mwin   <= pick_ref(m0_req, m1_req, mlast);
                    mlast  <= pick_ref(m0_req, m1_req, mlast);
                    maddr  <= pick_ref(m0_req, m1_req, mlast) ? m1_addr  : m0_addr;
                    mwe    <= pick_ref(m0_req, m1_req, mlast) ? m1_we    : m0_we;
                    mwd    <= pick_ref(m0_req, m1_req, mlast) ? m1_wdata : m0_wdata;
                    tphase <= 1;
                end
            end else if (tphase == 1) begin
                if (mwin) mrd1 <= ref_mem[maddr];
                else      mrd0 <= ref_mem[maddr];
                if (mwe) ref_mem[maddr] <= mwd;
                mack[mwin] <= 1'b1;
                tphase <= 2;
            end else begin
                tphase <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt++;
            we_addr_seen = ram_address;
        end
        if (m0_ack) ack_cnt0++;
        if (m1_ack) ack_cnt1++;
        if (!rst) begin
            check("ram_we",      {31'b0, ram_we}, {31'b0, (tphase == 1) && mwe});
            check("ram_address", 32'(ram_address), 32'(maddr));
            check("ram_datain",  32'(ram_datain), 32'(mwd));
            check("m0_ack",      {31'b0, m0_ack}, {31'b0, mack[0]});
            check("m1_ack",      {31'b0, m1_ack}, {31'b0, mack[1]});
            check("m0_rdata",    32'(m0_rdata), 32'(mrd0));
            check("m1_rdata",    32'(m1_rdata), 32'(mrd1));
            check("ack_overlap", {31'b0, m0_ack && m1_ack}, 32'd0);
        end
    end

    task automatic wait_ack(input int p, output int n);
        n = 0;
        forever begin
            @(posedge clk); #1;
            n++;
            if ((p == 0) ? m0_ack : m1_ack) break;
            if (n >= 20) begin
                checks++; errors++;
                $display("FAIL ack_timeout: port %0d got no ack within %0d cycles", p, n);
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a0, a1, w0, ovl, nack;
        int order[4];
        int when[4];
        int cyc;
        for (int i = 0; i < 32768; i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_m0_ack",   {31'b0, m0_ack}, 32'd0);
        check("rst_m1_ack",   {31'b0, m1_ack}, 32'd0);
        check("rst_ram_we",   {31'b0, ram_we}, 32'd0);
        check("rst_ram_addr", 32'(ram_address), 32'd0);
        check("rst_rdata",    32'({m0_rdata, m1_rdata}), 32'd0);
        rst = 1'b0;

        // Single read by port 0
        a1 = ack_cnt1; w0 = we_cnt;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 15'h0011;
        wait_ack(0, n);
        m0_req = 1'b0;
        check("t1_latency", n, 2);
        check("t1_rdata",   32'(m0_rdata), 32'h08);
        check("t1_no_we",   we_cnt - w0, 0);
        check("t1_m1_quiet", ack_cnt1 - a1, 0);

        // Write by port 1 returns old byte, then port 0 reads new byte
        @(posedge clk); #1;
        w0 = we_cnt;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 15'h0012; m1_wdata = 8'hA5;
        wait_ack(1, n);
        m1_req = 1'b0; m1_we = 1'b0;
        check("t2_latency", n, 2);
        check("t2_old_data", 32'(m1_rdata), 32'h01);
        check("t2_we_pulses", we_cnt - w0, 1);
        check("t2_we_addr", 32'(we_addr_seen), 32'h12);
        @(posedge clk); #1;
        m0_req = 1'b1; m0_addr = 15'h0012;
        wait_ack(0, n);
        m0_req = 1'b0;
        check("t2_readback", 32'(m0_rdata), 32'hA5);

        // Simultaneous requests after reset alternate 0,1,0,1
        pulse_reset();
        m0_req = 1'b1; m0_addr = 15'h0000; m1_req = 1'b1; m1_addr = 15'h0011;
        nack = 0; ovl = 0; cyc = 0;
        while (nack < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (m0_ack && m1_ack) ovl++;
            if (m0_ack || m1_ack) begin
                order[nack] = m1_ack ? 1 : 0;
                when[nack]  = cyc;
                nack++;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        check("t3_ack_count", nack, 4);
        check("t3_overlap", ovl, 0);
        check("t3_first_at", when[0], 2);
        for (int k = 0; k < 4; k++) check("t3_order", order[k], k % 2);
        for (int k = 1; k < 4; k++) check("t3_spacing", when[k] - when[k-1], 3);

        // Port 1 back-to-back reads, new address presented after each ack
        @(posedge clk); #1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 15'd0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(1, n);
            check("t4_period", n, (k == 0) ? 2 : 3);
            check("t4_rdata", 32'(m1_rdata), 32'(init_val(k)));
            m1_addr = 15'(k + 1);
        end
        m1_req = 1'b0;

        // Reset during a write ACCESS aborts it
        @(posedge clk); #1;
        pulse_reset();
        a0 = ack_cnt0; a1 = ack_cnt1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 15'd0; m0_wdata = 8'hFF;
        @(posedge clk); #1;
        check("t5_we_in_access", {31'b0, ram_we}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_we_dropped", {31'b0, ram_we}, 32'd0);
        m0_req = 1'b0; m0_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t5_no_ack0", ack_cnt0 - a0, 0);
        check("t5_no_ack1", ack_cnt1 - a1, 0);
        check("t5_mem0", 32'(mem[0]), 32'h04);
        m0_req = 1'b1; m0_addr = 15'h0011; m1_req = 1'b1; m1_addr = 15'h0012;
        cyc = 0;
        while (!(m0_ack || m1_ack) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        check("t5_tie_to_m0", {30'b0, m1_ack, m0_ack}, 32'd1);
        check("t5_tie_rdata", 32'(m0_rdata), 32'h08);

        // Random traffic on both ports, checked every cycle by the model
        repeat (3) @(posedge clk);
        fork
            begin
                for (int c = 0; c < 800; c++) begin
                    @(posedge clk); #1;
                    if (m0_req && m0_ack) begin
                        if ($urandom_range(0, 1) == 1) begin
                            m0_we = 1'($urandom_range(0, 1)); m0_addr = 15'($urandom_range(0, 15));
                            m0_wdata = 8'($urandom);
                        end else m0_req = 1'b0;
                    end else if (!m0_req && $urandom_range(0, 2) == 0) begin
                        m0_req = 1'b1; m0_we = 1'($urandom_range(0, 1));
                        m0_addr = 15'($urandom_range(0, 15)); m0_wdata = 8'($urandom);
                    end
                end
            end
            begin
                for (int c = 0; c < 800; c++) begin
                    @(posedge clk); #1;
                    if (m1_req && m1_ack) begin
                        if ($urandom_range(0, 1) == 1) begin
                            m1_we = 1'($urandom_range(0, 1)); m1_addr = 15'($urandom_range(0, 15));
                            m1_wdata = 8'($urandom);
                        end else m1_req = 1'b0;
                    end else if (!m1_req && $urandom_range(0, 2) == 0) begin
                        m1_req = 1'b1; m1_we = 1'($urandom_range(0, 1));
                        m1_addr = 15'($urandom_range(0, 15)); m1_wdata = 8'($urandom);
                    end
                end
            end
        join
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) check("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
